fetch_unit: RTL and testbench

Parametrised, pipelined instruction fetch stage replacing the combinational PC-to-instruction-memory path of the single-cycle processor. It owns the program counter and issues one read per cycle to a synchronous instruction memory with 1-cycle latency. Returned words are buffered, with their PC, in a prefetch queue of DEPTH entries and delivered to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and restarts fetch at a new target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch-queue entry type for the fetch stage.
// Optional perf counters in fetch_unit are enabled by FETCH_PERF_EN.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_DEPTH  = 4;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetched {pc, instr} entries.
// Flush is synchronous and overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + P1;
      if (pop_i)  rd_d = rd_q + P1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + C1;
        2'b01:   cnt_d = cnt_q - C1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined fetch stage: PC, credit-based issue, kill of stale responses.
// Define FETCH_PERF_EN to add perf_fetched/perf_bubble/perf_flush counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubble,
  output logic [31:0]       perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic [CW-1:0]     q_count;
  logic [CW:0]       used;
  logic              issue, push, pop;
  entry_t            head, rsp;

  // In-flight response holds a reserved slot, so the queue cannot overflow
  assign used  = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
  assign issue = !reset && (used < DEPTH_C);

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign push = inflight_q && !kill_q;
  assign pop  = out_valid && out_ready;

  assign rsp.pc    = rsp_pc_q;
  assign rsp.instr = imem_rdata;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = issue;
    kill_d     = redirect_valid;
    if (issue) begin
      pc_d     = pc_q + PC_INC;
      rsp_pc_d = pc_q;
    end
    if (redirect_valid) pc_d = redirect_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (rsp),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubble_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      bubble_q  <= '0;
      flush_q   <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      bubble_q  <= bubble_q + 32'(out_ready && !out_valid);
      flush_q   <= flush_q + 32'(redirect_valid);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubble  = bubble_q;
  assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors plus
// hand-written redirect, wrap and reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubble, perf_flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_INC   (32'h1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubble     (perf_bubble),
    .perf_flush      (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word at address a holds a + 0x100
  initial imem_rdata = '0;
  always @(posedge clk)
    if (imem_req) imem_rdata <= imem_addr + 32'h100;

  typedef struct {
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_pc"}, out_pc, pc);
    chk({nm, "_instr"}, out_instr, pc + 32'h100);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_req"}, 32'(imem_req), 32'd0);
    chk({nm, "_addr"}, imem_addr, 32'h0);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_pc"}, out_pc, 32'h0);
    chk({nm, "_instr"}, out_instr, 32'h0);
  endtask

  task automatic drive(input logic rv, input logic [31:0] rt,
                       input logic rdy);
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Leaves the bench at the first cycle after reset release (cycle 0)
  task automatic do_reset(input string nm);
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    out_ready       = 1'b0;
    #1;
    chk_rst(nm);
    next();
    next();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    out_ready       = 1'b0;

    for (int c = 0; c < 26; c++) begin
      tbl[c].rdy  = (c < 8) || (c >= 18);
      tbl[c].ev   = (c >= 2);
      tbl[c].epc  = (c < 8)  ? 32'(c - 2) :
                    (c < 18) ? 32'd6 : 32'(c - 12);
      tbl[c].ereq = !((c >= 10) && (c <= 18));
    end

    // Streaming, stall until the queue saturates, resume
    do_reset("rstA");
    for (int c = 0; c < 26; c++) begin
      drive(1'b0, 32'h0, tbl[c].rdy);
      chk($sformatf("A%0d_valid", c), 32'(out_valid), 32'(tbl[c].ev));
      chk($sformatf("A%0d_req", c), 32'(imem_req), 32'(tbl[c].ereq));
      if (tbl[c].ev) begin
        chk($sformatf("A%0d_pc", c), out_pc, tbl[c].epc);
        chk($sformatf("A%0d_instr", c), out_instr, tbl[c].epc + 32'h100);
      end
      next();
    end

    // Redirect with 3 queued entries and one response in flight
    do_reset("rstB");
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      next();
    end
    drive(1'b1, 32'h40, 1'b0);
    chk_head("B4", 32'h0);
    chk("B4_req", 32'(imem_req), 32'd0);
    next();
    drive(1'b0, 32'h0, 1'b0);
    chk_idle("B5");
    chk("B5_req", 32'(imem_req), 32'd1);
    chk("B5_addr", imem_addr, 32'h40);
    next();
    drive(1'b0, 32'h0, 1'b0);
    chk_idle("B6");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("B7", 32'h40);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("B8", 32'h41);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("B9", 32'h42);
    next();

    // Redirect together with the pop of PC 5, then wrap at 2^32-1
    do_reset("rstC");
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      next();
    end
    drive(1'b1, 32'h80, 1'b1);
    chk_head("C7", 32'h5);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("C8");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("C9");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("C10", 32'h80);
    next();
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    chk_head("C11", 32'h81);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("C12");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("C13");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("C14", 32'hFFFF_FFFF);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("C15", 32'h0);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("C16", 32'h1);
    chk("C16_req", 32'(imem_req), 32'd1);

    // Back-to-back redirects: the second target wins
    do_reset("rstMid");
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      next();
    end
    drive(1'b1, 32'h200, 1'b1);
    next();
    drive(1'b1, 32'h300, 1'b1);
    chk_idle("E6");
    chk("E6_addr", imem_addr, 32'h200);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("E7");
    chk("E7_addr", imem_addr, 32'h300);
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_idle("E8");
    next();
    drive(1'b0, 32'h0, 1'b1);
    chk_head("E9", 32'h300);
    next();

`ifdef FETCH_PERF_EN
    // 2 bubbles, 8 pops (last one with a redirect), 1 more bubble
    do_reset("rstP");
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      next();
    end
    drive(1'b1, 32'h500, 1'b1);
    next();
    drive(1'b0, 32'h0, 1'b1);
    next();
    drive(1'b0, 32'h0, 1'b0);
    next();
    drive(1'b0, 32'h0, 1'b0);
    chk("P_fetched", perf_fetched, 32'd8);
    chk("P_bubble", perf_bubble, 32'd3);
    chk("P_flush", perf_flush, 32'd1);
    reset = 1'b1;
    #1;
    chk("P_rst_fetched", perf_fetched, 32'd0);
    chk("P_rst_bubble", perf_bubble, 32'd0);
    chk("P_rst_flush", perf_flush, 32'd0);
`endif

    do_reset("rstEnd");
    drive(1'b0, 32'h0, 1'b1);
    chk("End0_req", 32'(imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
